// File: rtl/calc_core.sv
// Decimal two-operand calculator with a sequential double-dabble BCD converter.
// Build option: define CALC_MUL_EN to add multiply (op_val=2) and widen the datapath.
`timescale 1ns/1ps
module calc_core #(
    parameter int NDIG = 4,
    parameter int BW   = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_strobe,
    input  logic                is_number,
    input  logic                is_op,
    input  logic                is_eq,
    input  logic [3:0]          num_val,
    input  logic [1:0]          op_val,
    output logic [4*NDIG-1:0]   disp_bcd,
    output logic                disp_neg,
    output logic                err,
    output logic                busy
);
    function automatic longint f_maxv();
        longint v;
        v = 1;
        for (int i = 0; i < NDIG; i++) v = v * 10;
        return v - 1;
    endfunction

    localparam longint MAXV = f_maxv();
`ifdef CALC_MUL_EN
    localparam int MULW = $clog2(MAXV * MAXV + 1);
    localparam int W    = (BW > MULW) ? BW : MULW;
`else
    localparam int W    = BW;
`endif
    localparam int DW = 4 * NDIG;
    localparam int SW = $clog2(W + 1);
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        S_ENTER_A, S_OP_WAIT, S_ENTER_B, S_CONVERT, S_SHOW_RES, S_ERROR
    } state_t;

    state_t          r_state;
    logic            r_key_v;
    logic [W-1:0]    r_a, r_b, r_res, r_dd_bin;
    logic [DW-1:0]   r_a_bcd, r_b_bcd, r_dd_bcd, r_disp_bcd;
    logic [CW-1:0]   r_a_cnt, r_b_cnt;
    logic [SW-1:0]   r_step;
    logic [1:0]      r_op;
    logic            r_neg, r_busy, r_disp_neg, r_err;

    // Key classification; a key with no flag set is CLR, a reserved operator is dropped.
    logic w_op_ok, w_dig, w_op, w_eq, w_clr;
`ifdef CALC_MUL_EN
    assign w_op_ok = (op_val != 2'd3);
`else
    assign w_op_ok = ~op_val[1];
`endif
    assign w_dig = r_key_v & is_number;
    assign w_op  = r_key_v & ~is_number & is_op & w_op_ok;
    assign w_eq  = r_key_v & ~is_number & ~is_op & is_eq;
    assign w_clr = r_key_v & ~is_number & ~is_op & ~is_eq;

    logic [W-1:0]  w_d, w_a_app, w_b_app, w_maxv;
    logic [DW-1:0] w_d_bcd, w_a_bcd_app, w_b_bcd_app;
    assign w_d         = W'(num_val);
    assign w_d_bcd     = DW'(num_val);
    assign w_maxv      = W'(MAXV);
    assign w_a_app     = r_a * W'(10) + w_d;
    assign w_b_app     = r_b * W'(10) + w_d;
    assign w_a_bcd_app = (r_a_bcd << 4) | w_d_bcd;
    assign w_b_bcd_app = (r_b_bcd << 4) | w_d_bcd;

    logic [W:0]   w_diff;
    logic         w_a_lt_b;
    logic [W-1:0] w_sum, w_mag;
    assign w_sum    = r_a + r_b;
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};
    assign w_a_lt_b = w_diff[W];
    assign w_mag    = w_a_lt_b ? (r_b - r_a) : w_diff[W-1:0];

    logic [W-1:0] w_res;
    logic         w_res_neg, w_ovf;
    always_comb begin
        w_res     = w_sum;
        w_res_neg = 1'b0;
        w_ovf     = (w_sum > w_maxv);
        if (r_op == 2'd1) begin
            w_res = w_mag;
            w_res_neg = w_a_lt_b;
            w_ovf = 1'b0;
        end
`ifdef CALC_MUL_EN
        else if (r_op == 2'd2) begin
            w_res = r_a * r_b;
            w_ovf = ((r_a * r_b) > w_maxv);
        end
`endif
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    logic [DW-1:0] w_dd_adj, w_dd_bcd_next;
    logic [W-1:0]  w_dd_bin_next;
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dd
            assign w_dd_adj[4*gi +: 4] = (r_dd_bcd[4*gi +: 4] >= 4'd5) ?
                                         r_dd_bcd[4*gi +: 4] + 4'd3 : r_dd_bcd[4*gi +: 4];
        end
    endgenerate
    assign w_dd_bcd_next = (w_dd_adj << 1) | DW'(r_dd_bin[W-1]);
    assign w_dd_bin_next = r_dd_bin << 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_ENTER_A;
            r_key_v    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_dd_bin   <= '0;
            r_a_bcd    <= '0;
            r_b_bcd    <= '0;
            r_dd_bcd   <= '0;
            r_disp_bcd <= '0;
            r_a_cnt    <= '0;
            r_b_cnt    <= '0;
            r_step     <= '0;
            r_op       <= 2'd0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_disp_neg <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_key_v <= key_strobe;
            if (r_state == S_CONVERT) begin
                // First CONVERT clock loads the shifter; keys are ignored until the result lands.
                if (!r_busy) begin
                    r_busy   <= 1'b1;
                    r_dd_bin <= r_res;
                    r_dd_bcd <= '0;
                    r_step   <= '0;
                end else begin
                    r_dd_bin <= w_dd_bin_next;
                    r_dd_bcd <= w_dd_bcd_next;
                    r_step   <= r_step + SW'(1);
                    if (r_step == SW'(W - 1)) begin
                        r_busy     <= 1'b0;
                        r_disp_bcd <= w_dd_bcd_next;
                        r_disp_neg <= r_neg;
                        r_a        <= r_res;
                        r_a_bcd    <= w_dd_bcd_next;
                        r_a_cnt    <= CW'(NDIG);
                        r_state    <= S_SHOW_RES;
                    end
                end
            end else if (w_clr) begin
                r_a        <= '0;
                r_b        <= '0;
                r_a_bcd    <= '0;
                r_b_bcd    <= '0;
                r_a_cnt    <= '0;
                r_b_cnt    <= '0;
                r_err      <= 1'b0;
                r_disp_neg <= 1'b0;
                r_disp_bcd <= '0;
                r_state    <= S_ENTER_A;
            end else begin
                case (r_state)
                    S_ENTER_A: begin
                        if (w_dig && r_a_cnt < CW'(NDIG)) begin
                            r_a        <= w_a_app;
                            r_a_bcd    <= w_a_bcd_app;
                            r_a_cnt    <= r_a_cnt + CW'(1);
                            r_disp_bcd <= w_a_bcd_app;
                        end else if (w_op) begin
                            r_op    <= op_val;
                            r_state <= S_OP_WAIT;
                        end
                    end
                    S_OP_WAIT: begin
                        if (w_dig) begin
                            r_b        <= w_d;
                            r_b_bcd    <= w_d_bcd;
                            r_b_cnt    <= CW'(1);
                            r_disp_bcd <= w_d_bcd;
                            r_state    <= S_ENTER_B;
                        end else if (w_op) begin
                            r_op <= op_val;
                        end
                    end
                    S_ENTER_B: begin
                        if (w_dig && r_b_cnt < CW'(NDIG)) begin
                            r_b        <= w_b_app;
                            r_b_bcd    <= w_b_bcd_app;
                            r_b_cnt    <= r_b_cnt + CW'(1);
                            r_disp_bcd <= w_b_bcd_app;
                        end else if (w_eq) begin
                            r_res <= w_res;
                            r_neg <= w_res_neg;
                            if (w_ovf) begin
                                r_err      <= 1'b1;
                                r_disp_bcd <= '0;
                                r_disp_neg <= 1'b0;
                                r_state    <= S_ERROR;
                            end else begin
                                r_state <= S_CONVERT;
                            end
                        end
                    end
                    S_SHOW_RES: begin
                        if (w_dig) begin
                            r_a        <= w_d;
                            r_a_bcd    <= w_d_bcd;
                            r_a_cnt    <= CW'(1);
                            r_b        <= '0;
                            r_b_bcd    <= '0;
                            r_b_cnt    <= '0;
                            r_disp_neg <= 1'b0;
                            r_disp_bcd <= w_d_bcd;
                            r_state    <= S_ENTER_A;
                        end else if (w_op && !r_neg) begin
                            r_op    <= op_val;
                            r_state <= S_OP_WAIT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign disp_bcd = r_disp_bcd;
    assign disp_neg = r_disp_neg;
    assign err      = r_err;
    assign busy     = r_busy;
endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed scenarios plus random key streams
// checked against a decimal-level reference model.
`timescale 1ns/1ps
module tb_calc_core;
    localparam int NDIG = 4;
    localparam int BW   = 15;
`ifdef CALC_MUL_EN
    localparam int  CONV_LEN = 27;
    localparam bit  MUL      = 1'b1;
`else
    localparam int  CONV_LEN = 15;
    localparam bit  MUL      = 1'b0;
`endif
    localparam int MAXV = 9999;
    localparam int K_DIG = 0, K_OP = 1, K_EQ = 2, K_CLR = 3;
    localparam int MA = 0, MO = 1, MB = 2, MC = 3, MS = 4, ME = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_strobe = 1'b0;
    logic        is_number = 1'b0, is_op = 1'b0, is_eq = 1'b0;
    logic [3:0]  num_val = 4'd0;
    logic [1:0]  op_val = 2'd0;
    logic [15:0] disp_bcd;
    logic        disp_neg, err, busy;

    int n_vec = 0;
    int n_err = 0;

    int m_mode, m_a, m_b, m_na, m_nb, m_op, m_res, m_disp;
    bit m_neg, m_dneg, m_err;

    calc_core #(.NDIG(NDIG), .BW(BW)) dut (
        .clk(clk), .reset(reset), .key_strobe(key_strobe),
        .is_number(is_number), .is_op(is_op), .is_eq(is_eq),
        .num_val(num_val), .op_val(op_val),
        .disp_bcd(disp_bcd), .disp_neg(disp_neg), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit op_ok(input int v);
        return (v == 0) || (v == 1) || (MUL && v == 2);
    endfunction

    task automatic model_reset();
        m_mode = MA; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
        m_res = 0; m_disp = 0; m_neg = 0; m_dneg = 0; m_err = 0;
    endtask

    task automatic model_key(input int kind, input int val);
        int r;
        bit n;
        if (m_mode == MC) return;
        if (kind == K_CLR) begin
            m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
            m_err = 0; m_disp = 0; m_dneg = 0; m_mode = MA;
            return;
        end
        case (m_mode)
            MA: if (kind == K_DIG && m_na < NDIG) begin
                    m_a = m_a * 10 + val; m_na++; m_disp = m_a;
                end else if (kind == K_OP && op_ok(val)) begin
                    m_op = val; m_mode = MO;
                end
            MO: if (kind == K_DIG) begin
                    m_b = val; m_nb = 1; m_disp = m_b; m_mode = MB;
                end else if (kind == K_OP && op_ok(val)) m_op = val;
            MB: if (kind == K_DIG && m_nb < NDIG) begin
                    m_b = m_b * 10 + val; m_nb++; m_disp = m_b;
                end else if (kind == K_EQ) begin
                    n = 0;
                    if (m_op == 1) begin
                        n = (m_a < m_b);
                        r = n ? m_b - m_a : m_a - m_b;
                    end else if (m_op == 2) r = m_a * m_b;
                    else r = m_a + m_b;
                    if (m_op != 1 && r > MAXV) begin
                        m_err = 1; m_disp = 0; m_dneg = 0; m_mode = ME;
                    end else begin
                        m_res = r; m_neg = n; m_mode = MC;
                    end
                end
            MS: if (kind == K_DIG) begin
                    m_a = val; m_na = 1; m_b = 0; m_nb = 0;
                    m_dneg = 0; m_disp = val; m_mode = MA;
                end else if (kind == K_OP && op_ok(val) && !m_neg) begin
                    m_op = val; m_mode = MO;
                end
            default: ;
        endcase
    endtask

    task automatic press(input int kind, input int val);
        @(negedge clk);
        key_strobe = 1'b1;
        is_number  = (kind == K_DIG);
        is_op      = (kind == K_OP);
        is_eq      = (kind == K_EQ);
        num_val    = 4'(val);
        op_val     = 2'(val);
        @(negedge clk);
        key_strobe = 1'b0;
        @(negedge clk);
        is_number = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        model_key(kind, val);
        $display("key kind=%0d val=%0d -> bcd=%h neg=%b err=%b busy=%b",
                 kind, val, disp_bcd, disp_neg, err, busy);
    endtask

    // Waits out a conversion, optionally injecting a digit key while busy.
    task automatic wait_conv(input bit inject);
        int cnt = 0;
        int guard = 0;
        int inj = 0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start got=%b exp=0", busy);
        end
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (busy === 1'b1) cnt++;
            else if (cnt > 0) break;
            if (inject) begin
                case (inj)
                    0: if (cnt == 3) begin
                           key_strobe = 1'b1; is_number = 1'b1; num_val = 4'd9; inj = 1;
                       end
                    1: begin key_strobe = 1'b0; inj = 2; end
                    2: begin is_number = 1'b0; inj = 3; end
                    default: ;
                endcase
            end
        end
        key_strobe = 1'b0; is_number = 1'b0;
        n_vec++;
        if (cnt !== CONV_LEN) begin
            n_err++;
            $display("FAIL busy_len got=%0d exp=%0d", cnt, CONV_LEN);
        end
        model_finish();
    endtask

    task automatic model_finish();
        m_disp = m_res; m_dneg = m_neg; m_a = m_res; m_mode = MS;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_vec++;
        if ({disp_bcd, disp_neg, err, busy} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs got bcd=%h neg=%b err=%b busy=%b exp all 0",
                     disp_bcd, disp_neg, err, busy);
        end
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_add();
        press(K_DIG, 1); press(K_DIG, 2); press(K_OP, 0);
        press(K_DIG, 3); press(K_DIG, 4); press(K_EQ, 0);
        wait_conv(1'b0);
        n_vec++;
        if ({disp_bcd, disp_neg, err} !== {16'h0046, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_12_34 got bcd=%h neg=%b err=%b exp bcd=0046 neg=0 err=0",
                     disp_bcd, disp_neg, err);
        end
    endtask

    task automatic test_sub_neg();
        press(K_CLR, 0); press(K_DIG, 5); press(K_OP, 1);
        press(K_DIG, 8); press(K_EQ, 0);
        wait_conv(1'b0);
        n_vec++;
        if ({disp_bcd, disp_neg, err} !== {16'h0003, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_5_8 got bcd=%h neg=%b err=%b exp bcd=0003 neg=1 err=0",
                     disp_bcd, disp_neg, err);
        end
        press(K_OP, 0);
        n_vec++;
        if ({disp_bcd, disp_neg, busy} !== {16'h0003, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL neg_op_ignored got bcd=%h neg=%b busy=%b exp bcd=0003 neg=1 busy=0",
                     disp_bcd, disp_neg, busy);
        end
        press(K_DIG, 2);
        n_vec++;
        if ({disp_bcd, disp_neg} !== {16'h0002, 1'b0}) begin
            n_err++;
            $display("FAIL digit_after_neg got bcd=%h neg=%b exp bcd=0002 neg=0",
                     disp_bcd, disp_neg);
        end
    endtask

    task automatic test_overflow();
        press(K_CLR, 0);
        for (int i = 0; i < 4; i++) press(K_DIG, 9);
        press(K_OP, 0); press(K_DIG, 1); press(K_EQ, 0);
        n_vec++;
        if ({disp_bcd, disp_neg, err, busy} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL overflow got bcd=%h neg=%b err=%b busy=%b exp bcd=0000 neg=0 err=1 busy=0",
                     disp_bcd, disp_neg, err, busy);
        end
        press(K_DIG, 5);
        n_vec++;
        if ({disp_bcd, err} !== {16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL error_holds got bcd=%h err=%b exp bcd=0000 err=1", disp_bcd, err);
        end
        press(K_CLR, 0);
        n_vec++;
        if ({disp_bcd, err} !== {16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL clr_error got bcd=%h err=%b exp bcd=0000 err=0", disp_bcd, err);
        end
        press(K_DIG, 7);
        n_vec++;
        if (disp_bcd !== 16'h0007) begin
            n_err++;
            $display("FAIL clr_enter_a got bcd=%h exp bcd=0007", disp_bcd);
        end
    endtask

    task automatic test_digit_limit();
        press(K_CLR, 0);
        for (int i = 1; i <= 5; i++) press(K_DIG, i);
        n_vec++;
        if (disp_bcd !== 16'h1234) begin
            n_err++;
            $display("FAIL fifth_digit got bcd=%h exp bcd=1234", disp_bcd);
        end
        press(K_OP, 0); press(K_DIG, 0); press(K_EQ, 0);
        wait_conv(1'b0);
        n_vec++;
        if ({disp_bcd, disp_neg, err} !== {16'h1234, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_zero got bcd=%h neg=%b err=%b exp bcd=1234 neg=0 err=0",
                     disp_bcd, disp_neg, err);
        end
    endtask

    task automatic test_back_to_back();
        press(K_CLR, 0); press(K_DIG, 7); press(K_OP, 0);
        press(K_DIG, 8); press(K_EQ, 0);
        wait_conv(1'b0);
        n_vec++;
        if (disp_bcd !== 16'h0015) begin
            n_err++;
            $display("FAIL chain_first got bcd=%h exp bcd=0015", disp_bcd);
        end
        press(K_OP, 0); press(K_DIG, 5); press(K_EQ, 0);
        wait_conv(1'b1);
        n_vec++;
        if ({disp_bcd, disp_neg, err} !== {16'h0020, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL chain_second got bcd=%h neg=%b err=%b exp bcd=0020 neg=0 err=0",
                     disp_bcd, disp_neg, err);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({disp_bcd, busy} !== {16'h0020, 1'b0}) begin
            n_err++;
            $display("FAIL busy_key_dropped got bcd=%h busy=%b exp bcd=0020 busy=0", disp_bcd, busy);
        end
    endtask

    task automatic test_reset_mid_convert();
        int guard = 0;
        press(K_CLR, 0); press(K_DIG, 1); press(K_OP, 0);
        press(K_DIG, 2); press(K_EQ, 0);
        while (busy !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL convert_start got busy=%b exp busy=1", busy);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        n_vec++;
        if ({disp_bcd, disp_neg, err, busy} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid_convert got bcd=%h neg=%b err=%b busy=%b exp all 0",
                     disp_bcd, disp_neg, err, busy);
        end
        reset = 1'b1;
        press(K_DIG, 3); press(K_EQ, 0);
        repeat (4) @(negedge clk);
        n_vec++;
        if ({disp_bcd, busy} !== {16'h0003, 1'b0}) begin
            n_err++;
            $display("FAIL eq_in_enter_a got bcd=%h busy=%b exp bcd=0003 busy=0", disp_bcd, busy);
        end
    endtask

    task automatic test_random();
        int r, kind, val;
        press(K_CLR, 0);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      begin kind = K_DIG; val = $urandom_range(0, 9); end
            else if (r < 65) begin kind = K_OP;  val = $urandom_range(0, 3); end
            else if (r < 92) begin kind = K_EQ;  val = 0; end
            else             begin kind = K_CLR; val = 0; end
            press(kind, val);
            if (m_mode == MC) wait_conv(1'b0);
            n_vec++;
            if ({disp_bcd, disp_neg, err, busy} !== {to_bcd(m_disp), m_dneg, m_err, 1'b0}) begin
                n_err++;
                $display("FAIL random_%0d got bcd=%h neg=%b err=%b busy=%b exp bcd=%h neg=%b err=%b busy=0",
                         i, disp_bcd, disp_neg, err, busy, to_bcd(m_disp), m_dneg, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_sub_neg();
        test_overflow();
        test_digit_limit();
        test_back_to_back();
        test_reset_mid_convert();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Decimal calculator engine; consumes decoded key events from the keypad interface (key strobe plus number/op/eq flags and values).
- Accumulates two operands and applies + or −.
- Converts the result to BCD with a sequential double-dabble converter and drives digit/sign/error outputs for the display block.
- Sits between the keypad interface and the 7-segment display driver.

Parameters:
- NDIG, 4: operand/result digits; max value 10^NDIG−1.
- BW, 15: binary datapath width; must hold 2·(10^NDIG−1); 15 for NDIG=4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- key_strobe  in  1  one-clk pulse from keypad interface (btn_pressed); flags below are valid the clock AFTER the strobe.
- is_number  in  1  key is digit.
- is_op  in  1  key is operator.
- is_eq  in  1  key is '='.
- num_val  in  4  digit 0..9.
- op_val  in  2  0=add, 1=sub, 2/3 reserved.
- disp_bcd  out  4*NDIG  BCD digits shown; digit 0 in [3:0].
- disp_neg  out  1  shown value is negative.
- err  out  1  overflow latched.
- busy  out  1  BCD conversion in progress.

Behaviour:
- Reset (reset=0 at clk edge): state=ENTER_A; A=B=0; op=add; all outputs 0. Reset mid-CONVERT aborts the conversion.
- Key acceptance: key_strobe is delayed 1 clk internally (key_v). On key_v, the flags are sampled.
  - Key classes: DIG (is_number); OP (is_op, op_val 0/1); EQ (is_eq); CLR (key_v with all three flags 0).
  - op_val 2/3 is ignored.
  - Key_v while busy=1 is dropped, with no queueing.
- Operand entry: shifts the BCD register left one digit, inserting d; binary value ← value·10+d (same edge). A digit past NDIG digits is ignored. Leading zeros count as digits.
- CLR in any state: A=B=0, err=0, disp_neg=0, disp_bcd=0, state→ENTER_A.
- States:
  - ENTER_A
    - DIG→append to A; disp_bcd shows A.
    - OP→latch op, go to OP_WAIT.
    - EQ ignored.
  - OP_WAIT
    - DIG→B=d, go to ENTER_B; disp_bcd shows B.
    - OP→replace op.
    - EQ ignored.
    - disp_bcd keeps A.
  - ENTER_B
    - DIG→append to B.
    - OP ignored.
    - EQ→compute R on the same edge:
      - add: R=A+B.
      - sub: R=|A−B|, neg=(A<B).
      - Add with R>10^NDIG−1 → ERROR: err=1, disp_bcd=0, disp_neg=0.
      - Otherwise → CONVERT.
  - CONVERT
    - busy=1 for exactly BW clks (one double-dabble shift per clk).
    - On the edge busy drops: disp_bcd=BCD(R), disp_neg=neg, state→SHOW_RES, A=R.
    - disp outputs hold their previous values throughout CONVERT.
  - SHOW_RES
    - DIG→A=d, B=0, disp_neg=0, go to ENTER_A.
    - OP→if neg=0: keep A=R, latch op, go to OP_WAIT; if neg=1, OP ignored.
    - EQ ignored.
  - ERROR: only CLR exits; all other keys ignored; err held at 1.
- Latency: '=' strobe at edge t → flags sampled at t+1 → busy high from t+2 for BW clks → result visible at t+2+BW.
- Subtraction uses a BW+1-bit compare/subtract. No other sign state exists; operands are always non-negative.

Optional Feature:
- Macro: CALC_MUL_EN.
- When defined:
  - op_val=2 is multiply, R=A·B.
  - The internal datapath width becomes max(BW, bits for (10^NDIG−1)^2) = 27 for NDIG=4; CONVERT lasts that many clks.
  - R>10^NDIG−1 → ERROR.
- When undefined: op_val=2 is ignored like 3; width and CONVERT length are BW.

Test Plan:
- Keys 1,2,+,3,4,= → busy high exactly 15 clks; then disp_bcd=16'h0046, disp_neg=0, err=0.
- Keys 5,−,8,= → disp_bcd=16'h0003, disp_neg=1. Then + → ignored (state stays SHOW_RES). Then 2 → disp_bcd=16'h0002, disp_neg=0.
- Keys 9,9,9,9,+,1,= → err=1, disp_bcd=0. Then 5 → no change. Then CLR → err=0, disp_bcd=0, ENTER_A.
- Keys 1,2,3,4,5 → disp_bcd=16'h1234 (fifth digit dropped). Then +,0,= → 16'h1234.
- Chaining: 7,+,8,= → 16'h0015. Then +,5,= → 16'h0020. A key strobe injected while busy → dropped; result unchanged.
- Reset low on the 5th CONVERT clk → next edge: busy=0, disp_bcd=0, err=0. Keys 3,= → still 16'h0003 with no result (EQ ignored in ENTER_A).
